// File: rtl/mac_feeder.sv
// Job sequencer for a pipelined signed MAC: one bias beat plus K operand pairs in, one dot product out.
// Optional build macro MAC_FEED_SAT_EN saturates the result to the signed RW range instead of truncating.
module mac_feeder #(
    parameter int INW     = 16,
    parameter int OUTW    = 64,
    parameter int RW      = 32,
    parameter int K       = 4,
    parameter int MAC_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [INW-1:0]  in_a,
    input  logic [INW-1:0]  in_b,
    output logic [INW-1:0]  mac_input0,
    output logic [INW-1:0]  mac_input1,
    output logic [INW-1:0]  mac_init_value,
    output logic            mac_init_acc,
    output logic            mac_input_valid,
    input  logic [OUTW-1:0] mac_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   out_data
);

    localparam int CW = $clog2(K + 1);
    localparam int WW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    typedef enum logic [1:0] {BIAS, ACC, DRAIN, OUT} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [WW-1:0]   wait_reg, wait_next;
    logic            accept;
    logic [RW-1:0]   result;

`ifdef MAC_FEED_SAT_EN
    // The value fits when every bit from the RW sign bit upward agrees.
    logic [OUTW-RW:0] upper_bits;
    logic             fits;
    logic [RW-1:0]    sat_min;
    assign upper_bits = mac_out[OUTW-1:RW-1];
    assign fits       = (&upper_bits) | ~(|upper_bits);
    assign sat_min    = RW'(1) << (RW - 1);
    assign result     = fits ? mac_out[RW-1:0] : (mac_out[OUTW-1] ? sat_min : ~sat_min);
`else
    logic unused_mac_bits;
    assign unused_mac_bits = ^mac_out;
    assign result          = mac_out[RW-1:0];
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wait_next  = wait_reg;
        in_ready   = 1'b0;
        case (state_reg)
            BIAS: begin
                in_ready = !reset;
                if (in_valid && !reset) begin
                    cnt_next   = '0;
                    state_next = ACC;
                end
            end
            ACC: begin
                in_ready = !reset;
                if (in_valid && !reset) begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == CW'(K - 1)) begin
                        wait_next  = '0;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // One extra edge past MAC_LAT so the capture sees the final accumulator.
                wait_next = wait_reg + WW'(1);
                if (wait_reg == WW'(MAC_LAT)) begin
                    wait_next  = '0;
                    state_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_next = BIAS;
            end
            default: state_next = BIAS;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= BIAS;
            cnt_reg   <= '0;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wait_reg  <= wait_next;
        end
    end

    // MAC strobes are single-cycle; operand and init values hold between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_input0      <= '0;
            mac_input1      <= '0;
            mac_init_value  <= '0;
            mac_init_acc    <= 1'b0;
            mac_input_valid <= 1'b0;
            out_valid       <= 1'b0;
            out_data        <= '0;
        end else begin
            mac_init_acc    <= 1'b0;
            mac_input_valid <= 1'b0;
            if (accept && state_reg == BIAS) begin
                mac_init_acc   <= 1'b1;
                mac_init_value <= in_a;
            end
            if (accept && state_reg == ACC) begin
                mac_input_valid <= 1'b1;
                mac_input0      <= in_a;
                mac_input1      <= in_b;
            end
            if (state_reg == DRAIN && wait_reg == WW'(MAC_LAT)) begin
                out_data  <= result;
                out_valid <= 1'b1;
            end
            if (state_reg == OUT && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural two-stage signed MAC attached.
module tb_mac_feeder;

    localparam int INW = 16, OUTW = 64, RW = 32, K = 4, MAC_LAT = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [INW-1:0]  in_a = '0;
    logic [INW-1:0]  in_b = '0;
    logic [INW-1:0]  mac_input0, mac_input1, mac_init_value;
    logic            mac_init_acc, mac_input_valid;
    logic [OUTW-1:0] mac_out;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [RW-1:0]   out_data;

    int pass_cnt = 0;
    int total_cnt = 0;
    int init_cnt = 0, iv_cnt = 0, overlap_cnt = 0;
    int jbias;
    int ja[K], jb[K];

    always #5 clk = ~clk;

    mac_feeder #(.INW(INW), .OUTW(OUTW), .RW(RW), .K(K), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_input0(mac_input0), .mac_input1(mac_input1), .mac_init_value(mac_init_value),
        .mac_init_acc(mac_init_acc), .mac_input_valid(mac_input_valid), .mac_out(mac_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Behavioural MAC: product registered on the first edge, accumulated on the second.
    logic signed [OUTW-1:0]    acc_m, prod_m;
    logic                      pv_m;
    logic signed [2*INW-1:0]   prod_w;
    assign prod_w  = $signed(mac_input0) * $signed(mac_input1);
    assign mac_out = acc_m;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_m  <= '0;
            prod_m <= '0;
            pv_m   <= 1'b0;
        end else begin
            pv_m <= mac_input_valid;
            if (mac_input_valid) prod_m <= prod_w;
            if (mac_init_acc) acc_m <= $signed(mac_init_value);
            else if (pv_m) acc_m <= acc_m + prod_m;
        end
    end

    always @(negedge clk) begin
        if (mac_init_acc) init_cnt++;
        if (mac_input_valid) iv_cnt++;
        if (mac_init_acc && (mac_input_valid || pv_m)) overlap_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input int a, input int b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_a = INW'(a);
        in_b = INW'(b);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total_cnt++;
            $display("FAIL beat_timeout in_ready got 0 required 1");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_job(input int gap);
        send_beat(jbias, 0, gap);
        for (int i = 0; i < K; i++) send_beat(ja[i], jb[i], gap);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) begin
            total_cnt++;
            $display("FAIL out_timeout out_valid got 0 required 1");
        end
    endtask

    task automatic get_result(output logic signed [RW-1:0] d, output int lat);
        wait_out(lat);
        d = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic set_job(input int bias, input int a0, input int b0, input int a1, input int b1,
                           input int a2, input int b2, input int a3, input int b3);
        jbias = bias;
        ja[0] = a0; jb[0] = b0; ja[1] = a1; jb[1] = b1;
        ja[2] = a2; jb[2] = b2; ja[3] = a3; jb[3] = b3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b required 0", in_ready); else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b required 0", out_valid); else pass_cnt++;
        total_cnt++;
        if (out_data !== '0) $display("FAIL reset_out_data got %0h required 0", out_data); else pass_cnt++;
        total_cnt++;
        if ({mac_init_acc, mac_input_valid} !== 2'b00)
            $display("FAIL reset_mac_strobes got %b required 00", {mac_init_acc, mac_input_valid});
        else pass_cnt++;
        total_cnt++;
        if ({mac_input0, mac_input1, mac_init_value} !== '0)
            $display("FAIL reset_mac_data got %0h required 0", {mac_input0, mac_input1, mac_init_value});
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b required 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_basic_job();
        logic signed [RW-1:0] d;
        int lat, ic0, iv0;
        ic0 = init_cnt;
        iv0 = iv_cnt;
        set_job(10, 1, 2, 3, 4, -5, 6, 7, -8);
        send_job(0);
        get_result(d, lat);
        total_cnt++;
        if (d !== -32'sd62) $display("FAIL basic_data got %0d required -62", d); else pass_cnt++;
        total_cnt++;
        if (lat !== 3) $display("FAIL basic_latency got %0d required 3", lat); else pass_cnt++;
        total_cnt++;
        if (init_cnt - ic0 !== 1) $display("FAIL basic_init_pulses got %0d required 1", init_cnt - ic0); else pass_cnt++;
        total_cnt++;
        if (iv_cnt - iv0 !== 4) $display("FAIL basic_valid_pulses got %0d required 4", iv_cnt - iv0); else pass_cnt++;
    endtask

    task automatic test_gaps();
        logic signed [RW-1:0] d;
        int lat, iv0;
        iv0 = iv_cnt;
        set_job(10, 1, 2, 3, 4, -5, 6, 7, -8);
        send_job(2);
        get_result(d, lat);
        total_cnt++;
        if (d !== -32'sd62) $display("FAIL gaps_data got %0d required -62", d); else pass_cnt++;
        total_cnt++;
        if (iv_cnt - iv0 !== 4) $display("FAIL gaps_valid_pulses got %0d required 4", iv_cnt - iv0); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic signed [RW-1:0] d;
        int lat;
        set_job(10, 1, 2, 3, 4, -5, 6, 7, -8);
        send_job(0);
        wait_out(lat);
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if ($signed(out_data) !== -32'sd62) $display("FAIL hold_data c%0d got %0d required -62", c, $signed(out_data)); else pass_cnt++;
            total_cnt++;
            if (out_valid !== 1'b1) $display("FAIL hold_valid c%0d got %b required 1", c, out_valid); else pass_cnt++;
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL hold_in_ready c%0d got %b required 0", c, in_ready); else pass_cnt++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL hold_release out_valid got %b required 0", out_valid); else pass_cnt++;
        set_job(0, 1, 1, 1, 1, 1, 1, 1, 1);
        send_job(0);
        get_result(d, lat);
        total_cnt++;
        if (d !== 32'sd4) $display("FAIL next_job_data got %0d required 4", d); else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic signed [RW-1:0] d, exp_d;
        int lat;
`ifdef MAC_FEED_SAT_EN
        exp_d = 32'sd2147483647;
`else
        exp_d = -32'sd262140;
`endif
        set_job(0, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
        send_job(0);
        get_result(d, lat);
        total_cnt++;
        if (d !== exp_d) $display("FAIL sat_data got %0d required %0d", d, exp_d); else pass_cnt++;
    endtask

    task automatic test_reset_mid_job();
        logic signed [RW-1:0] d;
        int lat, seen;
        set_job(5, 9, 9, 9, 9, 9, 9, 9, 9);
        send_beat(jbias, 0, 0);
        send_beat(ja[0], jb[0], 0);
        send_beat(ja[1], jb[1], 0);
        reset = 1'b1;
        #1;
        total_cnt++;
        if (mac_input_valid !== 1'b0) $display("FAIL midrst_input_valid got %b required 0", mac_input_valid); else pass_cnt++;
        total_cnt++;
        if ({mac_input0, mac_input1, mac_init_value} !== '0)
            $display("FAIL midrst_mac_data got %0h required 0", {mac_input0, mac_input1, mac_init_value});
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got %b required 0", in_ready); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL midrst_no_result got %0d required 0", seen); else pass_cnt++;
        set_job(1, 2, 3, 2, 3, 2, 3, 2, 3);
        send_job(0);
        get_result(d, lat);
        total_cnt++;
        if (d !== 32'sd25) $display("FAIL midrst_fresh_data got %0d required 25", d); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic signed [RW-1:0] d1, d2;
        int lat, bad, n, ov0;
        ov0 = overlap_cnt;
        set_job(10, 1, 2, 3, 4, -5, 6, 7, -8);
        send_job(0);
        in_a = INW'(1);
        in_valid = 1'b1;
        bad = 0;
        n = 0;
        while (!out_valid && n < 50) begin
            if (in_ready) bad++;
            @(negedge clk);
            n++;
        end
        if (in_ready) bad++;
        d1 = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if (bad !== 0 || n >= 50) $display("FAIL b2b_in_ready_low got %0d ready cycles required 0", bad); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_result got %b required 1", in_ready); else pass_cnt++;
        total_cnt++;
        if (d1 !== -32'sd62) $display("FAIL b2b_first_data got %0d required -62", d1); else pass_cnt++;
        set_job(1, 2, 3, 2, 3, 2, 3, 2, 3);
        send_job(0);
        get_result(d2, lat);
        total_cnt++;
        if (d2 !== 32'sd25) $display("FAIL b2b_second_data got %0d required 25", d2); else pass_cnt++;
        total_cnt++;
        if (overlap_cnt - ov0 !== 0) $display("FAIL b2b_init_overlap got %0d required 0", overlap_cnt - ov0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_gaps();
        test_backpressure();
        test_saturation();
        test_reset_mid_job();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
